// File: rtl/uart_mult_pkg.sv
// rtl/uart_mult_pkg.sv - shared types, constants and sizing helpers for the byte-stream multiplier
package uart_mult_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        MULT      = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    function automatic int bytes_per_operand(input int width);
        return width / BYTE_W;
    endfunction

    function automatic int bytes_per_product(input int width);
        return (2 * width) / BYTE_W;
    endfunction

endpackage

// File: rtl/uart_mult_engine_if.sv
// rtl/uart_mult_engine_if.sv - byte receive, byte transmit and status bundle of the multiplier engine
interface uart_mult_engine_if #(
    parameter int WIDTH = 8
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               tx_ready;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic [2*WIDTH-1:0] result;
    logic               result_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_start, result, result_valid, busy, overrun
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_start, result, result_valid, busy, overrun
    );
endinterface

// File: rtl/uart_mult_engine_mult.sv
// rtl/uart_mult_engine_mult.sv - unsigned radix-2 shift-add multiplier, one multiplier bit per cycle
module seq_shift_add_mult
    import uart_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // The start cycle already consumes b[0], so WIDTH-1 iterations remain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier  <= b >> 1;
                cnt     <= CW'(WIDTH - 1);
                running <= 1'b1;
            end else if (running) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    product <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mult_engine.sv
// rtl/uart_mult_engine.sv - collects two MSB-first operands, multiplies them and serializes the product
module uart_mult_engine
    import uart_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_mult_engine_if.slave bus
);
    localparam int BPO = bytes_per_operand(WIDTH);
    localparam int BPP = bytes_per_product(WIDTH);
    localparam int PW  = 2 * WIDTH;

    state_t          state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]      rx_cnt;
    logic [3:0]      tx_cnt;
    logic [PW-1:0]   tx_shift;
    logic [PW-1:0]   result;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            result_valid;
    logic            busy;
    logic            overrun;
    logic            mult_start;
    logic            mult_done;
    logic [PW-1:0]   mult_product;
    logic            rx_last;

    assign rx_last = (rx_cnt == 4'(BPO - 1));

    seq_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mult_start),
        .a       (a),
        .b       (b),
        .done    (mult_done),
        .product (mult_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD_A;
            a            <= '0;
            b            <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            tx_shift     <= '0;
            result       <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            mult_start   <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            result_valid <= 1'b0;
            mult_start   <= 1'b0;
            // Bytes arriving outside the load states are judged by the state they land in.
            overrun <= bus.rx_valid && (state inside {MULT, SEND, WAIT_ACK, WAIT_DONE});
            case (state)
                LOAD_A: begin
                    if (bus.rx_valid) begin
                        a    <= WIDTH'({a, bus.rx_data});
                        busy <= 1'b1;
                        if (rx_last) begin
                            rx_cnt <= '0;
                            state  <= LOAD_B;
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.rx_valid) begin
                        b <= WIDTH'({b, bus.rx_data});
                        if (rx_last) begin
                            rx_cnt     <= '0;
                            mult_start <= 1'b1;
                            state      <= MULT;
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                MULT: begin
                    if (mult_done) begin
                        result       <= mult_product;
                        result_valid <= 1'b1;
                        tx_shift     <= mult_product;
                        tx_cnt       <= 4'(BPP);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        tx_data  <= tx_shift[PW-1 -: BYTE_W];
                        tx_start <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!bus.tx_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_ready) begin
                        tx_cnt   <= tx_cnt - 4'd1;
                        tx_shift <= tx_shift << BYTE_W;
                        if (tx_cnt == 4'd1) begin
                            busy  <= 1'b0;
                            state <= LOAD_A;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign bus.tx_data      = tx_data;
    assign bus.tx_start     = tx_start;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.busy         = busy;
    assign bus.overrun      = overrun;

endmodule

// File: tb/tb_uart_mult_engine.sv
// tb/tb_uart_mult_engine.sv - scoreboard bench for 8- and 16-bit multiplier engines
module tb_uart_mult_engine;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    uart_mult_engine_if #(.WIDTH(8))  b8 ();
    uart_mult_engine_if #(.WIDTH(16)) b16 ();

    uart_mult_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst), .bus(b8));
    uart_mult_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst), .bus(b16));

    logic [15:0] exp_res8[$];
    logic [7:0]  exp_tx8[$];
    logic [31:0] exp_res16[$];
    logic [7:0]  exp_tx16[$];
    logic        hold8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push8(input logic [15:0] r);
        exp_res8.push_back(r);
        exp_tx8.push_back(r[15:8]);
        exp_tx8.push_back(r[7:0]);
    endtask

    task automatic send(input int inst, input logic [7:0] d);
        if (inst == 8) begin b8.rx_data = d; b8.rx_valid = 1'b1; end
        else begin b16.rx_data = d; b16.rx_valid = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        b8.rx_valid  = 1'b0;
        b16.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (inst == 8) done = (exp_res8.size() == 0 && exp_tx8.size() == 0 && !b8.busy);
            else done = (exp_res16.size() == 0 && exp_tx16.size() == 0 && !b16.busy);
        end
        check($sformatf("idle%0d_reached", inst), 64'(done), 64'd1);
    endtask

    // Monitor and transmitter model for the 8-bit engine share one process so
    // that ready changes are ordered after the sampling of each cycle.
    initial begin
        logic [7:0] cur;
        bit pend, prev_start, prev_rv;
        int txcnt;
        pend = 0; prev_start = 0; prev_rv = 0; txcnt = 0;
        forever begin
            @(negedge clk);
            if (b8.result_valid) begin
                check("res8_pulse_width", 64'(prev_rv), 64'd0);
                if (exp_res8.size() == 0) check("res8_unexpected", 64'(b8.result), 64'hdead);
                else check("res8_value", 64'(b8.result), 64'(exp_res8.pop_front()));
            end
            if (pend && !b8.tx_start) check("tx8_data_stable", 64'(b8.tx_data), 64'(cur));
            if (b8.tx_start) begin
                check("tx8_start_width", 64'(prev_start), 64'd0);
                if (exp_tx8.size() == 0) check("tx8_unexpected", 64'(b8.tx_data), 64'h1dead);
                else check("tx8_byte", 64'(b8.tx_data), 64'(exp_tx8.pop_front()));
                cur = b8.tx_data;
                pend = 1;
            end
            prev_start = b8.tx_start;
            prev_rv = b8.result_valid;
            if (b8.tx_start) txcnt = 10;
            else if (txcnt > 0) txcnt--;
            b8.tx_ready = !(hold8 || txcnt > 0);
            if (b8.tx_ready) pend = 0;
        end
    end

    initial begin
        logic [7:0] cur;
        bit pend, prev_start;
        int txcnt;
        pend = 0; prev_start = 0; txcnt = 0;
        forever begin
            @(negedge clk);
            if (b16.result_valid) begin
                if (exp_res16.size() == 0) check("res16_unexpected", 64'(b16.result), 64'hdead);
                else check("res16_value", 64'(b16.result), 64'(exp_res16.pop_front()));
            end
            if (pend && !b16.tx_start) check("tx16_data_stable", 64'(b16.tx_data), 64'(cur));
            if (b16.tx_start) begin
                check("tx16_start_width", 64'(prev_start), 64'd0);
                if (exp_tx16.size() == 0) check("tx16_unexpected", 64'(b16.tx_data), 64'h1dead);
                else check("tx16_byte", 64'(b16.tx_data), 64'(exp_tx16.pop_front()));
                cur = b16.tx_data;
                pend = 1;
            end
            prev_start = b16.tx_start;
            if (b16.tx_start) txcnt = 10;
            else if (txcnt > 0) txcnt--;
            b16.tx_ready = !(txcnt > 0);
            if (b16.tx_ready) pend = 0;
        end
    end

    initial begin
        int n;
        int starts;
        tests = 0;
        fails = 0;
        hold8 = 0;
        b8.rx_data = 8'h00;  b8.rx_valid = 1'b0;  b8.tx_ready = 1'b1;
        b16.rx_data = 8'h00; b16.rx_valid = 1'b0; b16.tx_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_data", 64'(b8.tx_data), 64'h0);
        check("rst_tx_start", 64'(b8.tx_start), 64'h0);
        check("rst_result", 64'(b8.result), 64'h0);
        check("rst_result_valid", 64'(b8.result_valid), 64'h0);
        check("rst_busy", 64'(b8.busy), 64'h0);
        check("rst_overrun", 64'(b8.overrun), 64'h0);
        check("rst16_result", 64'(b16.result), 64'h0);

        // 3 * 5
        push8(16'h000F);
        send(8, 8'h03);
        check("busy_after_first_byte", 64'(b8.busy), 64'h1);
        send(8, 8'h05);
        wait_idle(8);

        // 255 * 255
        push8(16'hFE01);
        send(8, 8'hFF);
        send(8, 8'hFF);
        wait_idle(8);

        // 16-bit engine: 0x1234 * 0x5678
        exp_res16.push_back(32'h06260060);
        exp_tx16.push_back(8'h06); exp_tx16.push_back(8'h26);
        exp_tx16.push_back(8'h00); exp_tx16.push_back(8'h60);
        send(16, 8'h12);
        send(16, 8'h34);
        check("busy16_mid_frame", 64'(b16.busy), 64'h1);
        send(16, 8'h56);
        send(16, 8'h78);
        wait_idle(16);

        // Zero operand still runs full length: result_valid 9 edges after last B byte
        push8(16'h0000);
        send(8, 8'h00);
        send(8, 8'hA5);
        n = 0;
        while (!b8.result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("zero_result_latency", 64'(n), 64'd9);
        wait_idle(8);

        // Overrun during MULT and during WAIT_DONE: 7 * 9 = 0x3F
        push8(16'h003F);
        send(8, 8'h07);
        send(8, 8'h09);
        send(8, 8'h77);
        check("overrun_in_mult", 64'(b8.overrun), 64'h1);
        @(negedge clk);
        check("overrun_pulse_end", 64'(b8.overrun), 64'h0);
        n = 0;
        while (!b8.tx_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("overrun_tx_start_seen", 64'(b8.tx_start), 64'h1);
        repeat (4) @(negedge clk);
        send(8, 8'h77);
        check("overrun_in_wait_done", 64'(b8.overrun), 64'h1);
        wait_idle(8);
        push8(16'h0006);
        send(8, 8'h02);
        send(8, 8'h03);
        wait_idle(8);

        // Transmitter held busy for 50 cycles after result: 0x10 * 0x11 = 0x0110
        hold8 = 1;
        push8(16'h0110);
        send(8, 8'h10);
        send(8, 8'h11);
        n = 0;
        while (!b8.result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_result_seen", 64'(b8.result_valid), 64'h1);
        starts = 0;
        repeat (50) begin
            @(negedge clk);
            starts += int'(b8.tx_start);
        end
        check("hold_no_tx_start", 64'(starts), 64'd0);
        hold8 = 0;
        wait_idle(8);

        // Reset during the fourth MULT cycle aborts the frame
        send(8, 8'h09);
        send(8, 8'h0B);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_tx_data", 64'(b8.tx_data), 64'h0);
        check("abort_tx_start", 64'(b8.tx_start), 64'h0);
        check("abort_result", 64'(b8.result), 64'h0);
        check("abort_result_valid", 64'(b8.result_valid), 64'h0);
        check("abort_busy", 64'(b8.busy), 64'h0);
        check("abort_overrun", 64'(b8.overrun), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        push8(16'h0006);
        send(8, 8'h02);
        send(8, 8'h03);
        wait_idle(8);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
